// File: rtl/color_blob_tracker.sv
// YCbCr pixel classifier with a 3-stage YCbCr->RGB pipeline and per-class per-frame blob statistics
// (count, bounding box, coordinate sums) reported at frame end through a valid/ack handshake.
module color_blob_tracker #(
  parameter int N_CLASS    = 2,
  parameter int X_W        = 10,
  parameter int Y_W        = 10,
  parameter int CNT_W      = 19,
  parameter int MIN_PIXELS = 16
) (
  input  logic                         PCLK,
  input  logic                         rst_n,
  input  logic                         e_pix,
  input  logic [7:0]                   Y,
  input  logic [7:0]                   Cb,
  input  logic [7:0]                   Cr,
  input  logic [X_W-1:0]               x,
  input  logic [Y_W-1:0]               y,
  input  logic                         frame_start,
  input  logic                         frame_end,
  input  logic [N_CLASS-1:0]           cfg_en,
  input  logic [N_CLASS*8-1:0]         cfg_y_min,
  input  logic [N_CLASS*8-1:0]         cfg_y_max,
  input  logic [N_CLASS*8-1:0]         cfg_cb_min,
  input  logic [N_CLASS*8-1:0]         cfg_cb_max,
  input  logic [N_CLASS*8-1:0]         cfg_cr_min,
  input  logic [N_CLASS*8-1:0]         cfg_cr_max,
  output logic                         pix_valid,
  output logic [N_CLASS-1:0]           pix_class,
  output logic [7:0]                   R_out,
  output logic [7:0]                   G_out,
  output logic [7:0]                   B_out,
  output logic [7:0]                   Y_dec,
  output logic [X_W-1:0]               x_out,
  output logic [Y_W-1:0]               y_out,
  output logic                         stat_valid,
  input  logic                         stat_ack,
  output logic                         stat_overrun,
  output logic [N_CLASS*CNT_W-1:0]     stat_count,
  output logic [N_CLASS*X_W-1:0]       stat_xmin,
  output logic [N_CLASS*X_W-1:0]       stat_xmax,
  output logic [N_CLASS*Y_W-1:0]       stat_ymin,
  output logic [N_CLASS*Y_W-1:0]       stat_ymax,
  output logic [N_CLASS*(CNT_W+X_W)-1:0] stat_sum_x,
  output logic [N_CLASS*(CNT_W+Y_W)-1:0] stat_sum_y,
  output logic [N_CLASS-1:0]           stat_found
);

  localparam int SX_W = CNT_W + X_W;
  localparam int SY_W = CNT_W + Y_W;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, REPORT} state_t;

  // ---------------- S1: luma, centred chroma, coordinates ----------------
  logic              s1_valid;
  logic [7:0]        s1_luma;
  logic signed [8:0] s1_cb, s1_cr;
  logic [X_W-1:0]    s1_x;
  logic [Y_W-1:0]    s1_y;

  // NOTE: every clocked block uses <= so all registers see pre-edge values regardless of statement order.
  always_ff @(posedge PCLK or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_luma  <= '0;
      s1_cb    <= '0;
      s1_cr    <= '0;
      s1_x     <= '0;
      s1_y     <= '0;
    end else begin
      s1_valid <= e_pix;
      if (e_pix) begin
        s1_luma <= Y;
        s1_cb   <= 9'({1'b0, Cb}) - 9'd128;
        s1_cr   <= 9'({1'b0, Cr}) - 9'd128;
        s1_x    <= x;
        s1_y    <= y;
      end
    end
  end

  // ---------------- S2: colour-matrix products ----------------
  logic signed [19:0] cb_ext, cr_ext;
  logic signed [19:0] prod_r, prod_g_cb, prod_g_cr, prod_b;
  assign cb_ext = 20'(s1_cb);
  assign cr_ext = 20'(s1_cr);

  // NOTE: combinational blocks assign every output up front so no path leaves a value unassigned (no latches).
  always_comb begin
    prod_r    = cr_ext * 20'sd1436;
    prod_g_cb = cb_ext * 20'sd352;
    prod_g_cr = cr_ext * 20'sd730;
    prod_b    = cb_ext * 20'sd1815;
  end

  logic              s2_valid;
  logic [7:0]        s2_luma;
  logic signed [8:0] s2_cb, s2_cr;
  logic signed [9:0] s2_pr, s2_pg_cb, s2_pg_cr, s2_pb;
  logic [X_W-1:0]    s2_x;
  logic [Y_W-1:0]    s2_y;

  // Upper product bits are the arithmetic >>>10 (floor); every result fits in 10 signed bits.
  always_ff @(posedge PCLK or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_luma  <= '0;
      s2_cb    <= '0;
      s2_cr    <= '0;
      s2_pr    <= '0;
      s2_pg_cb <= '0;
      s2_pg_cr <= '0;
      s2_pb    <= '0;
      s2_x     <= '0;
      s2_y     <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_luma  <= s1_luma;
        s2_cb    <= s1_cb;
        s2_cr    <= s1_cr;
        s2_pr    <= prod_r[19:10];
        s2_pg_cb <= prod_g_cb[19:10];
        s2_pg_cr <= prod_g_cr[19:10];
        s2_pb    <= prod_b[19:10];
        s2_x     <= s1_x;
        s2_y     <= s1_y;
      end
    end
  end

  // ---------------- S3: sums, clamp, classification ----------------
  function automatic logic [7:0] clamp_u8(input logic signed [11:0] v);
    if (v < 12'sd0)   return 8'd0;
    if (v > 12'sd255) return 8'd255;
    return v[7:0];
  endfunction

  logic signed [11:0] luma_ext, r_sum, g_sum, b_sum;
  logic [N_CLASS-1:0] class_hit;

  always_comb begin
    luma_ext  = signed'({4'b0, s2_luma});
    r_sum     = luma_ext + 12'(s2_pr);
    g_sum     = luma_ext - 12'(s2_pg_cb) - 12'(s2_pg_cr);
    b_sum     = luma_ext + 12'(s2_pb);
    class_hit = '0;
    for (int c = 0; c < N_CLASS; c++) begin
      class_hit[c] = cfg_en[c]
        && (s2_luma >= cfg_y_min[c*8 +: 8]) && (s2_luma <= cfg_y_max[c*8 +: 8])
        && (s2_cb >= 9'($signed(cfg_cb_min[c*8 +: 8]))) && (s2_cb <= 9'($signed(cfg_cb_max[c*8 +: 8])))
        && (s2_cr >= 9'($signed(cfg_cr_min[c*8 +: 8]))) && (s2_cr <= 9'($signed(cfg_cr_max[c*8 +: 8])));
    end
  end

  always_ff @(posedge PCLK or negedge rst_n) begin
    if (!rst_n) begin
      pix_valid <= 1'b0;
      pix_class <= '0;
      R_out     <= '0;
      G_out     <= '0;
      B_out     <= '0;
      Y_dec     <= '0;
      x_out     <= '0;
      y_out     <= '0;
    end else begin
      pix_valid <= s2_valid;
      if (s2_valid) begin
        pix_class <= class_hit;
        R_out     <= clamp_u8(r_sum);
        G_out     <= clamp_u8(g_sum);
        B_out     <= clamp_u8(b_sum);
        Y_dec     <= (|class_hit) ? 8'hFF : s2_luma;
        x_out     <= s2_x;
        y_out     <= s2_y;
      end
    end
  end

  // ---------------- Frame FSM ----------------
  state_t     state;
  logic [1:0] drain_cnt;

  always_ff @(posedge PCLK or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      drain_cnt <= '0;
    end else begin
      case (state)
        IDLE:   if (frame_start) state <= ACCUM;
        ACCUM:  if (frame_end) begin
                  state     <= DRAIN;
                  drain_cnt <= '0;
                end
        DRAIN:  if (drain_cnt == 2'd2) state <= REPORT;
                else drain_cnt <= drain_cnt + 2'd1;
        REPORT: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // A restart inside ACCUM discards the partial frame unless frame_end arrives in the same cycle.
  logic acc_clear, acc_en;
  always_comb begin
    acc_clear = (state == REPORT)
             || (state == IDLE  && frame_start)
             || (state == ACCUM && frame_start && !frame_end);
    acc_en    = (state == ACCUM) || (state == DRAIN);
  end

  // ---------------- Per-class accumulators ----------------
  logic [CNT_W-1:0] acc_count [N_CLASS];
  logic [X_W-1:0]   acc_xmin  [N_CLASS];
  logic [X_W-1:0]   acc_xmax  [N_CLASS];
  logic [Y_W-1:0]   acc_ymin  [N_CLASS];
  logic [Y_W-1:0]   acc_ymax  [N_CLASS];
  logic [SX_W-1:0]  acc_sum_x [N_CLASS];
  logic [SY_W-1:0]  acc_sum_y [N_CLASS];

  // NOTE: these arrays are a handful of flops, not RAM, so resetting them costs nothing and keeps reports clean.
  always_ff @(posedge PCLK or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < N_CLASS; c++) begin
        acc_count[c] <= '0;
        acc_xmin[c]  <= '1;
        acc_xmax[c]  <= '0;
        acc_ymin[c]  <= '1;
        acc_ymax[c]  <= '0;
        acc_sum_x[c] <= '0;
        acc_sum_y[c] <= '0;
      end
    end else begin
      for (int c = 0; c < N_CLASS; c++) begin
        if (acc_clear) begin
          acc_count[c] <= '0;
          acc_xmin[c]  <= '1;
          acc_xmax[c]  <= '0;
          acc_ymin[c]  <= '1;
          acc_ymax[c]  <= '0;
          acc_sum_x[c] <= '0;
          acc_sum_y[c] <= '0;
        end else if (acc_en && pix_valid && pix_class[c]) begin
          if (acc_count[c] != '1) acc_count[c] <= acc_count[c] + 1'b1;
          if (x_out < acc_xmin[c]) acc_xmin[c] <= x_out;
          if (x_out > acc_xmax[c]) acc_xmax[c] <= x_out;
          if (y_out < acc_ymin[c]) acc_ymin[c] <= y_out;
          if (y_out > acc_ymax[c]) acc_ymax[c] <= y_out;
          acc_sum_x[c] <= acc_sum_x[c] + SX_W'(x_out);
          acc_sum_y[c] <= acc_sum_y[c] + SY_W'(y_out);
        end
      end
    end
  end

  // ---------------- Report registers and handshake ----------------
  always_ff @(posedge PCLK or negedge rst_n) begin
    if (!rst_n) begin
      stat_valid   <= 1'b0;
      stat_overrun <= 1'b0;
      stat_count   <= '0;
      stat_xmin    <= '1;
      stat_xmax    <= '0;
      stat_ymin    <= '1;
      stat_ymax    <= '0;
      stat_sum_x   <= '0;
      stat_sum_y   <= '0;
      stat_found   <= '0;
    end else if (state == REPORT) begin
      // A coincident ack retires the old report; the new one stays valid.
      stat_valid   <= 1'b1;
      stat_overrun <= stat_valid && !stat_ack;
      for (int c = 0; c < N_CLASS; c++) begin
        stat_count[c*CNT_W +: CNT_W] <= acc_count[c];
        stat_xmin[c*X_W +: X_W]      <= acc_xmin[c];
        stat_xmax[c*X_W +: X_W]      <= acc_xmax[c];
        stat_ymin[c*Y_W +: Y_W]      <= acc_ymin[c];
        stat_ymax[c*Y_W +: Y_W]      <= acc_ymax[c];
        stat_sum_x[c*SX_W +: SX_W]   <= acc_sum_x[c];
        stat_sum_y[c*SY_W +: SY_W]   <= acc_sum_y[c];
        stat_found[c]                <= (acc_count[c] >= CNT_W'(MIN_PIXELS));
      end
    end else if (stat_valid && stat_ack) begin
      stat_valid   <= 1'b0;
      stat_overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_color_blob_tracker.sv
// Directed bench for color_blob_tracker: conversion/clamp, classification, frame statistics,
// overrun handshake, frame restart, mid-frame reset and back-to-back pixel streaming.
module tb_color_blob_tracker;

  localparam int N_CLASS = 2;
  localparam int X_W     = 10;
  localparam int Y_W     = 10;
  localparam int CNT_W   = 19;
  localparam int SX_W    = CNT_W + X_W;
  localparam int SY_W    = CNT_W + Y_W;

  logic                      PCLK = 1'b0;
  logic                      rst_n;
  logic                      e_pix;
  logic [7:0]                Y, Cb, Cr;
  logic [X_W-1:0]            x;
  logic [Y_W-1:0]            y;
  logic                      frame_start, frame_end;
  logic [N_CLASS-1:0]        cfg_en;
  logic [N_CLASS*8-1:0]      cfg_y_min, cfg_y_max, cfg_cb_min, cfg_cb_max, cfg_cr_min, cfg_cr_max;
  logic                      pix_valid;
  logic [N_CLASS-1:0]        pix_class;
  logic [7:0]                R_out, G_out, B_out, Y_dec;
  logic [X_W-1:0]            x_out;
  logic [Y_W-1:0]            y_out;
  logic                      stat_valid, stat_ack, stat_overrun;
  logic [N_CLASS*CNT_W-1:0]  stat_count;
  logic [N_CLASS*X_W-1:0]    stat_xmin, stat_xmax;
  logic [N_CLASS*Y_W-1:0]    stat_ymin, stat_ymax;
  logic [N_CLASS*SX_W-1:0]   stat_sum_x;
  logic [N_CLASS*SY_W-1:0]   stat_sum_y;
  logic [N_CLASS-1:0]        stat_found;

  int n_cmp = 0;
  int n_bad = 0;

  color_blob_tracker #(.N_CLASS(N_CLASS), .X_W(X_W), .Y_W(Y_W), .CNT_W(CNT_W), .MIN_PIXELS(16)) dut (
    .PCLK(PCLK), .rst_n(rst_n), .e_pix(e_pix), .Y(Y), .Cb(Cb), .Cr(Cr), .x(x), .y(y),
    .frame_start(frame_start), .frame_end(frame_end), .cfg_en(cfg_en),
    .cfg_y_min(cfg_y_min), .cfg_y_max(cfg_y_max), .cfg_cb_min(cfg_cb_min), .cfg_cb_max(cfg_cb_max),
    .cfg_cr_min(cfg_cr_min), .cfg_cr_max(cfg_cr_max),
    .pix_valid(pix_valid), .pix_class(pix_class), .R_out(R_out), .G_out(G_out), .B_out(B_out),
    .Y_dec(Y_dec), .x_out(x_out), .y_out(y_out),
    .stat_valid(stat_valid), .stat_ack(stat_ack), .stat_overrun(stat_overrun),
    .stat_count(stat_count), .stat_xmin(stat_xmin), .stat_xmax(stat_xmax),
    .stat_ymin(stat_ymin), .stat_ymax(stat_ymax), .stat_sum_x(stat_sum_x), .stat_sum_y(stat_sum_y),
    .stat_found(stat_found)
  );

  always #5 PCLK = ~PCLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic drive_pix(input logic [7:0] yy, input logic [7:0] cb, input logic [7:0] cr,
                           input logic [X_W-1:0] xx, input logic [Y_W-1:0] yc);
    e_pix = 1'b1; Y = yy; Cb = cb; Cr = cr; x = xx; y = yc;
    tick();
  endtask

  // Matching pixel (Y=100, Cb'=-108, Cr'=-68) for class 0, frame delimited by pulses, then report wait.
  task automatic run_frame(input int n, input int x0, input int yv);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    for (int i = 0; i < n; i++) drive_pix(8'd100, 8'd20, 8'd60, X_W'(x0 + i), Y_W'(yv));
    e_pix = 1'b0;
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    repeat (6) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    n_cmp++; if (pix_valid !== 1'b0) begin n_bad++; $display("FAIL reset_pix_valid: got %0d want 0", pix_valid); end
    n_cmp++; if ({R_out, G_out, B_out, Y_dec} !== 32'd0) begin n_bad++; $display("FAIL reset_rgb: got %h want 0", {R_out, G_out, B_out, Y_dec}); end
    n_cmp++; if (stat_valid !== 1'b0 || stat_overrun !== 1'b0) begin n_bad++; $display("FAIL reset_stat_flags: got %b%b want 00", stat_valid, stat_overrun); end
    n_cmp++; if (stat_xmin !== {(N_CLASS*X_W){1'b1}} || stat_ymin !== {(N_CLASS*Y_W){1'b1}}) begin n_bad++; $display("FAIL reset_stat_min: got %h/%h want all-ones", stat_xmin, stat_ymin); end
    n_cmp++; if (stat_count !== '0 || stat_xmax !== '0 || stat_found !== '0) begin n_bad++; $display("FAIL reset_stat_other: got %h/%h/%b want 0", stat_count, stat_xmax, stat_found); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_convert();
    // Neutral grey: no class match, unity output, valid for exactly one cycle after 3 edges.
    drive_pix(8'd128, 8'd128, 8'd128, 10'd7, 10'd9);
    e_pix = 1'b0;
    tick();
    n_cmp++; if (pix_valid !== 1'b0) begin n_bad++; $display("FAIL conv_latency_early: got %0d want 0", pix_valid); end
    tick();
    n_cmp++; if (pix_valid !== 1'b1) begin n_bad++; $display("FAIL conv_latency: got %0d want 1", pix_valid); end
    n_cmp++; if ({R_out, G_out, B_out} !== {8'd128, 8'd128, 8'd128}) begin n_bad++; $display("FAIL conv_grey: got %0d/%0d/%0d want 128/128/128", R_out, G_out, B_out); end
    n_cmp++; if (Y_dec !== 8'd128 || pix_class !== 2'b00) begin n_bad++; $display("FAIL conv_grey_class: got %0d/%b want 128/00", Y_dec, pix_class); end
    n_cmp++; if (x_out !== 10'd7 || y_out !== 10'd9) begin n_bad++; $display("FAIL conv_coords: got %0d/%0d want 7/9", x_out, y_out); end
    tick();
    n_cmp++; if (pix_valid !== 1'b0 || R_out !== 8'd128) begin n_bad++; $display("FAIL conv_hold: got %0d/%0d want 0/128", pix_valid, R_out); end
    // Floor + low clamp, and a class-0 match.
    drive_pix(8'd100, 8'd20, 8'd60, 10'd1, 10'd1);
    e_pix = 1'b0;
    repeat (2) tick();
    n_cmp++; if ({R_out, G_out, B_out} !== {8'd4, 8'd187, 8'd0}) begin n_bad++; $display("FAIL conv_floor: got %0d/%0d/%0d want 4/187/0", R_out, G_out, B_out); end
    n_cmp++; if (pix_class !== 2'b01 || Y_dec !== 8'd255) begin n_bad++; $display("FAIL conv_match: got %b/%0d want 01/255", pix_class, Y_dec); end
    // High clamp on R.
    drive_pix(8'd250, 8'd128, 8'd255, 10'd2, 10'd2);
    e_pix = 1'b0;
    repeat (2) tick();
    n_cmp++; if ({R_out, G_out, B_out} !== {8'd255, 8'd160, 8'd250}) begin n_bad++; $display("FAIL conv_clamp: got %0d/%0d/%0d want 255/160/250", R_out, G_out, B_out); end
    n_cmp++; if (pix_class !== 2'b00 || Y_dec !== 8'd250) begin n_bad++; $display("FAIL conv_clamp_class: got %b/%0d want 00/250", pix_class, Y_dec); end
    repeat (2) tick();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 9; i++) begin
      if (i < 6) begin
        if (i % 2 == 0) drive_pix(8'd100, 8'd20, 8'd60, X_W'(i), 10'd0);
        else            drive_pix(8'd128, 8'd128, 8'd128, X_W'(i), 10'd0);
      end else begin
        e_pix = 1'b0;
        tick();
      end
      if (i >= 2 && i < 8) begin
        n_cmp++; if (pix_valid !== 1'b1 || pix_class !== (((i - 2) % 2 == 0) ? 2'b01 : 2'b00) || x_out !== X_W'(i - 2))
          begin n_bad++; $display("FAIL b2b_%0d: got v=%0d c=%b x=%0d want v=1 c=%b x=%0d", i - 2, pix_valid, pix_class, x_out, ((i - 2) % 2 == 0) ? 2'b01 : 2'b00, i - 2); end
      end else if (i == 8) begin
        n_cmp++; if (pix_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_end: got %0d want 0", pix_valid); end
      end
    end
  endtask

  task automatic test_frame_stats();
    run_frame(20, 10, 5);
    n_cmp++; if (stat_valid !== 1'b1 || stat_overrun !== 1'b0) begin n_bad++; $display("FAIL frame_flags: got %b%b want 10", stat_valid, stat_overrun); end
    n_cmp++; if (stat_count[CNT_W-1:0] !== 19'd20) begin n_bad++; $display("FAIL frame_count: got %0d want 20", stat_count[CNT_W-1:0]); end
    n_cmp++; if (stat_xmin[X_W-1:0] !== 10'd10 || stat_xmax[X_W-1:0] !== 10'd29) begin n_bad++; $display("FAIL frame_x_box: got %0d..%0d want 10..29", stat_xmin[X_W-1:0], stat_xmax[X_W-1:0]); end
    n_cmp++; if (stat_ymin[Y_W-1:0] !== 10'd5 || stat_ymax[Y_W-1:0] !== 10'd5) begin n_bad++; $display("FAIL frame_y_box: got %0d..%0d want 5..5", stat_ymin[Y_W-1:0], stat_ymax[Y_W-1:0]); end
    n_cmp++; if (stat_sum_x[SX_W-1:0] !== 29'd390 || stat_sum_y[SY_W-1:0] !== 29'd100) begin n_bad++; $display("FAIL frame_sums: got %0d/%0d want 390/100", stat_sum_x[SX_W-1:0], stat_sum_y[SY_W-1:0]); end
    n_cmp++; if (stat_found !== 2'b01) begin n_bad++; $display("FAIL frame_found: got %b want 01", stat_found); end
    n_cmp++; if (stat_count[2*CNT_W-1:CNT_W] !== 19'd0 || stat_xmin[2*X_W-1:X_W] !== 10'h3FF || stat_xmax[2*X_W-1:X_W] !== 10'd0)
      begin n_bad++; $display("FAIL frame_class1_empty: got %0d/%h/%0d want 0/3ff/0", stat_count[2*CNT_W-1:CNT_W], stat_xmin[2*X_W-1:X_W], stat_xmax[2*X_W-1:X_W]); end
    stat_ack = 1'b1;
    tick();
    stat_ack = 1'b0;
    n_cmp++; if (stat_valid !== 1'b0) begin n_bad++; $display("FAIL frame_ack: got %0d want 0", stat_valid); end
  endtask

  task automatic test_overrun();
    run_frame(5, 100, 7);
    n_cmp++; if (stat_valid !== 1'b1 || stat_overrun !== 1'b0 || stat_count[CNT_W-1:0] !== 19'd5 || stat_found !== 2'b00)
      begin n_bad++; $display("FAIL ovr_first: got v=%0d o=%0d n=%0d f=%b want 1/0/5/00", stat_valid, stat_overrun, stat_count[CNT_W-1:0], stat_found); end
    run_frame(18, 200, 9);
    n_cmp++; if (stat_valid !== 1'b1 || stat_overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_flags: got %b%b want 11", stat_valid, stat_overrun); end
    n_cmp++; if (stat_count[CNT_W-1:0] !== 19'd18 || stat_found !== 2'b01) begin n_bad++; $display("FAIL ovr_count: got %0d/%b want 18/01", stat_count[CNT_W-1:0], stat_found); end
    n_cmp++; if (stat_xmin[X_W-1:0] !== 10'd200 || stat_xmax[X_W-1:0] !== 10'd217) begin n_bad++; $display("FAIL ovr_box: got %0d..%0d want 200..217", stat_xmin[X_W-1:0], stat_xmax[X_W-1:0]); end
    n_cmp++; if (stat_sum_x[SX_W-1:0] !== 29'd3753 || stat_sum_y[SY_W-1:0] !== 29'd162) begin n_bad++; $display("FAIL ovr_sums: got %0d/%0d want 3753/162", stat_sum_x[SX_W-1:0], stat_sum_y[SY_W-1:0]); end
    stat_ack = 1'b1;
    tick();
    stat_ack = 1'b0;
    n_cmp++; if (stat_valid !== 1'b0 || stat_overrun !== 1'b0 || stat_count[CNT_W-1:0] !== 19'd18)
      begin n_bad++; $display("FAIL ovr_ack: got v=%0d o=%0d n=%0d want 0/0/18", stat_valid, stat_overrun, stat_count[CNT_W-1:0]); end
  endtask

  task automatic test_restart();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    for (int i = 0; i < 10; i++) drive_pix(8'd100, 8'd20, 8'd60, X_W'(300 + i), 10'd3);
    e_pix = 1'b0;
    repeat (5) tick();
    run_frame(16, 50, 2);
    n_cmp++; if (stat_count[CNT_W-1:0] !== 19'd16 || stat_found !== 2'b01) begin n_bad++; $display("FAIL restart_count: got %0d/%b want 16/01", stat_count[CNT_W-1:0], stat_found); end
    n_cmp++; if (stat_xmin[X_W-1:0] !== 10'd50 || stat_xmax[X_W-1:0] !== 10'd65 || stat_ymin[Y_W-1:0] !== 10'd2 || stat_ymax[Y_W-1:0] !== 10'd2)
      begin n_bad++; $display("FAIL restart_box: got %0d..%0d,%0d..%0d want 50..65,2..2", stat_xmin[X_W-1:0], stat_xmax[X_W-1:0], stat_ymin[Y_W-1:0], stat_ymax[Y_W-1:0]); end
    n_cmp++; if (stat_sum_x[SX_W-1:0] !== 29'd920 || stat_sum_y[SY_W-1:0] !== 29'd32) begin n_bad++; $display("FAIL restart_sums: got %0d/%0d want 920/32", stat_sum_x[SX_W-1:0], stat_sum_y[SY_W-1:0]); end
  endtask

  task automatic test_reset_mid_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    for (int i = 0; i < 3; i++) drive_pix(8'd100, 8'd20, 8'd60, X_W'(400 + i), 10'd4);
    rst_n = 1'b0;
    e_pix = 1'b0;
    #1;
    n_cmp++; if (pix_valid !== 1'b0 || pix_class !== 2'b00 || {R_out, G_out, B_out, Y_dec} !== 32'd0 || x_out !== '0)
      begin n_bad++; $display("FAIL midrst_pix: got v=%0d c=%b rgb=%h x=%0d want all 0", pix_valid, pix_class, {R_out, G_out, B_out, Y_dec}, x_out); end
    n_cmp++; if (stat_valid !== 1'b0 || stat_count !== '0 || stat_found !== '0 || stat_sum_x !== '0)
      begin n_bad++; $display("FAIL midrst_stat: got v=%0d n=%h f=%b sx=%h want all 0", stat_valid, stat_count, stat_found, stat_sum_x); end
    n_cmp++; if (stat_xmin !== {(N_CLASS*X_W){1'b1}} || stat_ymin !== {(N_CLASS*Y_W){1'b1}}) begin n_bad++; $display("FAIL midrst_min: got %h/%h want all-ones", stat_xmin, stat_ymin); end
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    // frame_end while idle must not produce a report.
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    repeat (6) tick();
    n_cmp++; if (stat_valid !== 1'b0) begin n_bad++; $display("FAIL idle_frame_end: got %0d want 0", stat_valid); end
  endtask

  initial begin
    rst_n = 1'b0; e_pix = 1'b0; Y = '0; Cb = '0; Cr = '0; x = '0; y = '0;
    frame_start = 1'b0; frame_end = 1'b0; stat_ack = 1'b0;
    cfg_en     = 2'b01;
    cfg_y_min  = {8'd0,   8'd60};
    cfg_y_max  = {8'd255, 8'd180};
    cfg_cb_min = {8'h80,  8'h92};   // class0 Cb' -110
    cfg_cb_max = {8'h7F,  8'hAB};   // class0 Cb' -85
    cfg_cr_min = {8'h80,  8'h88};   // class0 Cr' -120
    cfg_cr_max = {8'h7F,  8'hD8};   // class0 Cr' -40
    test_reset();
    test_convert();
    test_back_to_back();
    test_frame_stats();
    test_overrun();
    test_restart();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
